mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port instruction/data memory between the fetch unit (IF) and the load/store path (DM).
//   Sits between the PC/fetch logic, the MemRW/ALU-address path and the memory macro.
//   Arbitrates requests and sequences one memory transaction at a time with a configurable read latency.
//   Returns read data or a write acknowledge to the winning requester; busy_o is the core stall.
// PARAMETERS
//   ADDR_W   32  width of address buses
//   DATA_W   32  width of data buses (byte enables = DATA_W/8)
//   MEM_LAT  1   memory read latency in cycles after accept; legal 1..4
// PORTS
//   clk          in   1         single clock; all state on rising edge
//   rst_n        in   1         synchronous, active-low reset
//   if_req_i     in   1         fetch request; held with if_addr_i until if_gnt_o
//   if_addr_i    in   ADDR_W    fetch address (PC)
//   if_gnt_o     out  1         fetch request accepted (1-cycle pulse)
//   if_rvalid_o  out  1         fetch data valid (1-cycle pulse)
//   if_rdata_o   out  DATA_W    fetched instruction, valid with if_rvalid_o
//   dm_req_i     in   1         load/store request; held with its fields until dm_gnt_o
//   dm_we_i      in   1         1 = store, 0 = load (MemRW)
//   dm_be_i      in   DATA_W/8  store byte enables
//   dm_addr_i    in   ADDR_W    ALU-computed data address
//   dm_wdata_i   in   DATA_W    store data
//   dm_gnt_o     out  1         data request accepted (1-cycle pulse)
//   dm_rvalid_o  out  1         load data valid or store acknowledge (1-cycle pulse)
//   dm_rdata_o   out  DATA_W    load data; 0 on store ack
//   mem_req_o    out  1         memory request; held until mem_ready_i
//   mem_we_o     out  1         memory write enable
//   mem_be_o     out  DATA_W/8  memory byte enables; all ones on reads
//   mem_addr_o   out  ADDR_W    memory address, unmodified from requester
//   mem_wdata_o  out  DATA_W    memory write data
//   mem_ready_i  in   1         memory accepts request this cycle
//   mem_rdata_i  in   DATA_W    read data, valid exactly MEM_LAT cycles after the accept cycle
//   busy_o       out  1         state != IDLE
// BEHAVIOUR
//   Reset: state IDLE, counter 0; every output 0, all data/address outputs included.
//   FSM states:
//   - IDLE: if dm_req_i, grant DM; else if if_req_i, grant IF.
//     DM has fixed priority over IF; at most one grant per cycle.
//     gnt is combinational in IDLE; the winner's fields are latched at that edge -> ISSUE.
//   - ISSUE: mem_req_o=1 with latched fields; stays in ISSUE until mem_ready_i.
//     On accept: write -> RESP; read -> WAIT with counter loaded to MEM_LAT-1.
//   - WAIT: counter decrements to 0; at counter==0, register mem_rdata_i -> RESP.
//   - RESP: owner's rvalid_o=1 for one cycle -> IDLE.
//   rdata_o is held until the next rvalid for the same port.
//   mem_* outputs are 0 outside ISSUE; fields never change while mem_req_o=1.
//   Latency (mem_ready_i high on first ISSUE cycle), with gnt at cycle t:
//   - load/fetch: rvalid at t+2+MEM_LAT.
//   - store: ack at t+2.
//   - next grant at earliest one cycle after RESP.
//   Requests arriving outside IDLE are not granted; requester keeps req high; no queuing.
//   Dropping req before gnt is legal and cancels the request.
//   dm_be_i==0 on a store is forwarded unchanged (memory no-op); still acked.
//   Reset mid-transaction: the transaction is abandoned, no rvalid, no further mem_req_o.
//   Memory data arriving after reset is ignored.
// TESTING
//   1. Reset: rst_n=0 two cycles during ISSUE -> all outputs 0 the cycle after; busy_o=0.
//   2. Fetch, MEM_LAT=1: if_req_i, addr 0x0000_0010 at t0 -> if_gnt_o t0, mem_req_o t1,
//      mem_rdata_i 0x0050_0093 at t2 -> if_rvalid_o with that data at t3.
//   3. Contention: if_req_i and dm_req_i both at t0 (load 0x100) -> dm_gnt_o t0, dm_rvalid_o t3;
//      if_gnt_o at t4; exactly one grant per cycle.
//   4. Store: dm_we_i=1, be=4'b0011, addr 0x200, wdata 0xDEAD_BEEF; mem_ready_i low for 3 cycles ->
//      fields stable, mem_req_o held; dm_rvalid_o 1 cycle after accept; dm_rdata_o=0.
//   5. MEM_LAT=3: load accepted at t1 -> mem_rdata_i sampled at t4, dm_rvalid_o at t5, busy_o low at t6.
//   6. rst_n low in WAIT -> no rvalid pulse; next request after reset completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and load/store (DM).
// One transaction at a time: grant in IDLE, hold request in ISSUE, count read latency in WAIT, pulse rvalid in RESP.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    output logic                dm_gnt_o,
    output logic                dm_rvalid_o,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_ready_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                owner_dm_q, owner_dm_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_dm_d  = owner_dm_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_gnt_o    = 1'b0;
        dm_gnt_o    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Gated by rst_n: a grant in a reset cycle would be discarded at the edge.
                if (rst_n && dm_req_i) begin
                    dm_gnt_o    = 1'b1;
                    owner_dm_d  = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_be_d    = dm_we_i ? dm_be_i : {BE_W{1'b1}};
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_we_i ? dm_wdata_i : '0;
                    state_d     = ISSUE;
                end else if (rst_n && if_req_i) begin
                    if_gnt_o    = 1'b1;
                    owner_dm_d  = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = {BE_W{1'b1}};
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready_i) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if (mem_we_q) begin
                        // Only the DM port can store; its ack carries zero data.
                        dm_rvalid_d = 1'b1;
                        dm_rdata_d  = '0;
                        state_d     = RESP;
                    end else begin
                        cnt_d   = 2'(MEM_LAT - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    dm_rvalid_d = owner_dm_q;
                    if_rvalid_d = !owner_dm_q;
                    if (owner_dm_q) dm_rdata_d = mem_rdata_i;
                    else            if_rdata_d = mem_rdata_i;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            owner_dm_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_dm_q  <= owner_dm_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_rvalid_o = if_rvalid_q;
    assign dm_rvalid_o = dm_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed latency/priority/reset scenarios plus randomized traffic,
// all checked every cycle against a transaction-timeline model.
module tb_mem_port_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_i, dm_req_i, dm_we_i, mem_ready_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
    logic [3:0]  dm_be_i;
    logic        if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o;
    logic        mem_req_o, mem_we_o, busy_o;
    logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
        .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // ---------------- Transaction-timeline reference model ----------------
    // A transaction is described by its grant, its accept cycle and the cycle its response is due.
    bit          m_live = 0;
    bit          m_busy = 0;
    bit          m_dm, m_we;
    logic [31:0] m_addr, m_wdata, m_rd_pend;
    logic [3:0]  m_be;
    int          m_accept, m_resp;
    logic [31:0] m_rd_if = '0, m_rd_dm = '0;
    int          cyc = 0;

    logic        e_if_gnt, e_dm_gnt, e_mreq, e_mwe, e_if_rv, e_dm_rv, e_busy;
    logic [31:0] e_maddr, e_mwdata;
    logic [3:0]  e_mbe;

    always @(negedge clk) begin
        if (m_live) begin
            e_if_gnt = 0; e_dm_gnt = 0; e_mreq = 0; e_mwe = 0; e_if_rv = 0; e_dm_rv = 0;
            e_busy = 0; e_maddr = '0; e_mwdata = '0; e_mbe = '0;
            if (!m_busy) begin
                if (rst_n && dm_req_i)      e_dm_gnt = 1;
                else if (rst_n && if_req_i) e_if_gnt = 1;
            end else begin
                e_busy = 1;
                if (m_accept < 0) begin
                    e_mreq = 1; e_mwe = m_we; e_maddr = m_addr; e_mwdata = m_wdata; e_mbe = m_be;
                end
                if (cyc == m_resp) begin
                    if (m_dm) begin
                        e_dm_rv = 1;
                        m_rd_dm = m_we ? 32'h0 : m_rd_pend;
                    end else begin
                        e_if_rv = 1;
                        m_rd_if = m_rd_pend;
                    end
                end
            end
            check("if_gnt", if_gnt_o, e_if_gnt);
            check("dm_gnt", dm_gnt_o, e_dm_gnt);
            check("mem_req", mem_req_o, e_mreq);
            check("mem_we", mem_we_o, e_mwe);
            check("mem_be", mem_be_o, e_mbe);
            check("mem_addr", mem_addr_o, e_maddr);
            check("mem_wdata", mem_wdata_o, e_mwdata);
            check("if_rvalid", if_rvalid_o, e_if_rv);
            check("dm_rvalid", dm_rvalid_o, e_dm_rv);
            check("if_rdata", if_rdata_o, m_rd_if);
            check("dm_rdata", dm_rdata_o, m_rd_dm);
            check("busy", busy_o, e_busy);
        end
        // Advance the model across the coming rising edge.
        if (!rst_n) begin
            m_live = 1; m_busy = 0; m_rd_if = '0; m_rd_dm = '0;
        end else if (m_live) begin
            if (!m_busy) begin
                if (e_dm_gnt || e_if_gnt) begin
                    m_busy = 1; m_dm = e_dm_gnt; m_accept = -1; m_resp = -1;
                    m_we    = e_dm_gnt && dm_we_i;
                    m_addr  = e_dm_gnt ? dm_addr_i : if_addr_i;
                    m_be    = m_we ? dm_be_i : 4'hF;
                    m_wdata = m_we ? dm_wdata_i : 32'h0;
                end
            end else begin
                if (m_accept < 0) begin
                    if (mem_ready_i) begin
                        m_accept = cyc;
                        m_resp   = cyc + 1 + (m_we ? 0 : LAT);
                    end
                end else if (!m_we && cyc == m_accept + LAT) begin
                    m_rd_pend = mem_rdata_i;
                end
                if (cyc == m_resp) m_busy = 0;
            end
        end
        cyc++;
    end

    // ---------------- Stimulus ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        next();
        if_req_i = 0; dm_req_i = 0; dm_we_i = 0; mem_ready_i = 1;
        for (int k = 0; k < 40 && busy_o; k++) next();
        @(negedge clk);
        check("drain_idle", busy_o, 1'b0);
        next();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gi, gd;
        rst_n = 0; if_req_i = 0; dm_req_i = 0; dm_we_i = 0; dm_be_i = '0;
        if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0; mem_ready_i = 0; mem_rdata_i = '0;
        next(); next();
        rst_n = 1;

        // Reset held two cycles while a fetch sits in ISSUE.
        if_req_i = 1; if_addr_i = 32'h40; mem_ready_i = 0;
        @(negedge clk); check("t1_gnt", if_gnt_o, 1'b1);
        next(); if_req_i = 0;
        @(negedge clk); check("t1_issue", mem_req_o, 1'b1);
        next(); rst_n = 0;
        next(); next(); rst_n = 1;
        @(negedge clk);
        check("t1_busy", busy_o, 1'b0);
        check("t1_mreq", mem_req_o, 1'b0);
        check("t1_maddr", mem_addr_o, 32'h0);
        check("t1_rvalid", if_rvalid_o, 1'b0);
        drain();

        // Fetch: rvalid lands at t0+2+LAT.
        if_req_i = 1; if_addr_i = 32'h0000_0010; mem_ready_i = 1; mem_rdata_i = 32'h0050_0093;
        @(negedge clk); check("t2_gnt", if_gnt_o, 1'b1);
        next(); if_req_i = 0;
        @(negedge clk);
        check("t2_mreq", mem_req_o, 1'b1);
        check("t2_maddr", mem_addr_o, 32'h10);
        check("t2_mbe", mem_be_o, 4'hF);
        repeat (LAT + 1) next();
        @(negedge clk);
        check("t2_rvalid", if_rvalid_o, 1'b1);
        check("t2_rdata", if_rdata_o, 32'h0050_0093);
        next();
        @(negedge clk); check("t2_idle", busy_o, 1'b0);
        drain();

        // Contention: DM wins, IF granted one cycle after DM's response.
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h100; if_req_i = 1; if_addr_i = 32'h44;
        mem_ready_i = 1; mem_rdata_i = 32'h1234_5678;
        @(negedge clk);
        check("t3_dm_gnt", dm_gnt_o, 1'b1);
        check("t3_if_gnt0", if_gnt_o, 1'b0);
        next(); dm_req_i = 0;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            check("t3_if_wait", if_gnt_o, 1'b0);
            if (k == LAT + 2) begin
                check("t3_dm_rvalid", dm_rvalid_o, 1'b1);
                check("t3_dm_rdata", dm_rdata_o, 32'h1234_5678);
            end
            next();
        end
        @(negedge clk); check("t3_if_gnt", if_gnt_o, 1'b1);
        drain();

        // Store with memory stalling three cycles.
        dm_req_i = 1; dm_we_i = 1; dm_be_i = 4'b0011; dm_addr_i = 32'h200;
        dm_wdata_i = 32'hDEAD_BEEF; mem_ready_i = 0;
        @(negedge clk); check("t4_gnt", dm_gnt_o, 1'b1);
        next(); dm_req_i = 0; dm_we_i = 0; dm_be_i = '0; dm_wdata_i = '0;
        repeat (3) begin
            @(negedge clk);
            check("t4_mreq", mem_req_o, 1'b1);
            check("t4_mwe", mem_we_o, 1'b1);
            check("t4_mbe", mem_be_o, 4'b0011);
            check("t4_maddr", mem_addr_o, 32'h200);
            check("t4_mwdata", mem_wdata_o, 32'hDEAD_BEEF);
            next();
        end
        mem_ready_i = 1;
        next(); mem_ready_i = 0;
        @(negedge clk);
        check("t4_ack", dm_rvalid_o, 1'b1);
        check("t4_ack_data", dm_rdata_o, 32'h0);
        drain();

        // Reset during WAIT abandons the load; a later fetch still completes.
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h300; mem_ready_i = 1;
        @(negedge clk); check("t6_gnt", dm_gnt_o, 1'b1);
        next(); dm_req_i = 0;
        next(); rst_n = 0;
        next(); rst_n = 1;
        repeat (LAT + 3) begin
            @(negedge clk);
            check("t6_no_rvalid", dm_rvalid_o, 1'b0);
            check("t6_no_busy", busy_o, 1'b0);
            next();
        end
        if_req_i = 1; if_addr_i = 32'h20; mem_rdata_i = 32'hCAFE_0001;
        @(negedge clk); check("t6_if_gnt", if_gnt_o, 1'b1);
        next(); if_req_i = 0;
        repeat (LAT + 1) next();
        @(negedge clk);
        check("t6_if_rvalid", if_rvalid_o, 1'b1);
        check("t6_if_rdata", if_rdata_o, 32'hCAFE_0001);
        drain();

        // Randomized traffic: held requests, cancellations, zero byte enables, stalls, resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            gi = if_gnt_o; gd = dm_gnt_o;
            next();
            rst_n = ($urandom_range(0, 199) != 0);
            if (gi || !if_req_i) begin
                if_req_i  = ($urandom_range(0, 2) == 0);
                if_addr_i = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                if_req_i = 0;
            end
            if (gd || !dm_req_i) begin
                dm_req_i   = ($urandom_range(0, 2) == 0);
                dm_we_i    = $urandom_range(0, 1);
                dm_be_i    = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
                dm_addr_i  = $urandom;
                dm_wdata_i = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                dm_req_i = 0;
            end
            mem_ready_i = $urandom_range(0, 1);
            mem_rdata_i = $urandom;
        end
        rst_n = 1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
